dsp_mac_slice: RTL and testbench

- Parametrised successor to the fixed 18x18/48-bit DSP48A1-style slice: pre-adder, signed multiplier, post-adder/accumulator.
- Configurable operand widths and pipeline depth.
- A valid bit travels through the pipeline alongside the data, and one global clock-enable stalls the whole pipeline.
- Optional saturation with an overflow flag.
- Used as the MAC engine in filter and correlator datapaths built on the Spartan-6 slice model.

---
 rtl/dsp_mac_pkg.sv | 35 +++
 rtl/dsp_pipe_reg.sv | 30 +++
 rtl/dsp_mac_slice.sv | 151 +++++++++++++++
 tb/tb_dsp_mac_slice.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_mac_pkg.sv
// Shared opmode field encodings and saturation-limit helpers for the DSP MAC slice.
package dsp_mac_pkg;

  typedef enum logic [1:0] {
    PRE_B     = 2'b00,
    PRE_ADD   = 2'b01,
    PRE_SUB   = 2'b10,
    PRE_B_ALT = 2'b11
  } pre_op_e;

  typedef enum logic [1:0] {
    POST_M    = 2'b00,
    POST_CM   = 2'b01,
    POST_ACC  = 2'b10,
    POST_CSUB = 2'b11
  } post_op_e;

  // Wide enough for any sensible P_W; callers truncate to their own width.
  localparam int LIM_W = 256;

  function automatic logic [LIM_W-1:0] sat_max(input int w);
    logic [LIM_W-1:0] r;
    r = '0;
    for (int i = 0; i < w - 1; i++) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [LIM_W-1:0] sat_min(input int w);
    logic [LIM_W-1:0] r;
    r = '0;
    r[w-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/dsp_pipe_reg.sv
// Delay line of DEPTH registers with shared clock enable and synchronous reset.
module dsp_pipe_reg #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst, ce};
    assign q = d;
  end else begin : g_reg
    logic [DEPTH-1:0][WIDTH-1:0] stg;
    always_ff @(posedge clk) begin
      if (rst) begin
        stg <= '0;
      end else if (ce) begin
        stg[0] <= d;
        for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
      end
    end
    assign q = stg[DEPTH-1];
  end

endmodule

// File: rtl/dsp_mac_slice.sv
// Parametrised pre-adder / signed multiplier / post-adder-accumulator slice with
// a valid bit riding alongside the data and a single global clock enable.
module dsp_mac_slice
  import dsp_mac_pkg::*;
#(
  parameter int A_W       = 18,
  parameter int B_W       = 18,
  parameter int P_W       = 48,
  parameter int IN_STAGES = 1,
  parameter int MREG      = 1,
  parameter int SAT_EN    = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  input  logic           in_valid,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  input  logic [B_W-1:0] d,
  input  logic [P_W-1:0] c,
  input  logic           cin,
  input  logic [3:0]     opmode,
  output logic           out_valid,
  output logic [P_W-1:0] p,
  output logic           carryout,
  output logic           ovf
);

  localparam int M_W  = A_W + B_W;
  localparam int AB_W = A_W + 2 * B_W;
  localparam logic [P_W-1:0] P_MAX = P_W'(sat_max(P_W));
  localparam logic [P_W-1:0] P_MIN = P_W'(sat_min(P_W));

  if (P_W < M_W + 1) begin : g_err_pw
    $error("dsp_mac_slice: P_W must be at least A_W+B_W+1");
  end
  if (IN_STAGES < 0 || IN_STAGES > 2) begin : g_err_in
    $error("dsp_mac_slice: IN_STAGES must be 0..2");
  end
  if (MREG < 0 || MREG > 1) begin : g_err_mreg
    $error("dsp_mac_slice: MREG must be 0 or 1");
  end

  // ---- input stages ----
  logic [AB_W-1:0] abd1;
  logic [A_W-1:0]  a1;
  logic [B_W-1:0]  b1, d1;
  logic            v1;
  logic [3:0]      op1;

  dsp_pipe_reg #(.WIDTH(AB_W), .DEPTH(IN_STAGES)) u_in_reg (
    .clk(clk), .rst(rst), .ce(ce), .d({a, b, d}), .q(abd1)
  );
  assign {a1, b1, d1} = abd1;

  dsp_pipe_reg #(.WIDTH(5), .DEPTH(IN_STAGES)) u_ctl_in (
    .clk(clk), .rst(rst), .ce(ce), .d({in_valid, opmode}), .q({v1, op1})
  );

  // c and cin skip the multiplier, so they are delayed to meet m at the post-adder.
  logic [P_W-1:0] c2;
  logic           cin2;

  dsp_pipe_reg #(.WIDTH(P_W + 1), .DEPTH(IN_STAGES + MREG)) u_c_dly (
    .clk(clk), .rst(rst), .ce(ce), .d({cin, c}), .q({cin2, c2})
  );

  // ---- pre-adder and multiplier ----
  logic [B_W-1:0]        pre1;
  logic signed [M_W-1:0] m1;

  always_comb begin
    pre1 = b1;
    case (pre_op_e'(op1[1:0]))
      PRE_ADD: pre1 = d1 + b1;
      PRE_SUB: pre1 = d1 - b1;
      default: pre1 = b1;
    endcase
  end

  assign m1 = M_W'($signed(a1)) * M_W'($signed(pre1));

  // ---- multiplier register ----
  logic [M_W-1:0] m2;
  logic           v2;
  logic [1:0]     post2;

  dsp_pipe_reg #(.WIDTH(M_W), .DEPTH(MREG)) u_mreg (
    .clk(clk), .rst(rst), .ce(ce), .d(m1), .q(m2)
  );

  dsp_pipe_reg #(.WIDTH(3), .DEPTH(MREG)) u_ctl_m (
    .clk(clk), .rst(rst), .ce(ce), .d({v1, op1[3:2]}), .q({v2, post2})
  );

  // ---- post-adder ----
  logic [P_W-1:0] mx, x, y, p_nxt;
  logic [P_W:0]   usum;
  logic [P_W+1:0] xe, me, ex;
  logic           sub, ovf_n;

  assign mx = {{(P_W - M_W){m2[M_W-1]}}, m2};

  always_comb begin
    x   = '0;
    y   = mx;
    sub = 1'b0;
    case (post_op_e'(post2))
      POST_CM:  x = c2;
      POST_ACC: x = p;
      POST_CSUB: begin
        x   = c2;
        y   = ~mx;
        sub = 1'b1;
      end
      default:  x = '0;
    endcase
  end

  // Unsigned sum gives p and carryout; the sign-extended exact sum gives overflow.
  assign usum = {1'b0, x} + {1'b0, y} + {{P_W{1'b0}}, sub} + {{P_W{1'b0}}, cin2};

  assign xe = {{2{x[P_W-1]}}, x};
  assign me = {{2{mx[P_W-1]}}, mx};
  assign ex = (sub ? xe - me : xe + me) + {{(P_W + 1){1'b0}}, cin2};

  assign ovf_n = (ex[P_W+1:P_W-1] != 3'b000) && (ex[P_W+1:P_W-1] != 3'b111);

  logic unused_ex_lo;
  assign unused_ex_lo = ^ex[P_W-2:0];

  assign p_nxt = (SAT_EN != 0 && ovf_n) ? (ex[P_W+1] ? P_MIN : P_MAX) : usum[P_W-1:0];

  // Results only move on a valid final-stage beat, so bubbles leave the accumulator alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      p         <= '0;
      carryout  <= 1'b0;
      ovf       <= 1'b0;
    end else if (ce) begin
      out_valid <= v2;
      if (v2) begin
        p        <= p_nxt;
        carryout <= usum[P_W];
        ovf      <= ovf_n;
      end
    end
  end

endmodule

// File: tb/tb_dsp_mac_slice.sv
// Randomised and directed bench for dsp_mac_slice; a wrapping and a saturating
// instance share stimulus and are checked against a 64-bit arithmetic model.
module tb_dsp_mac_slice;

  localparam logic [47:0] PMAXV = 48'h7FFF_FFFF_FFFF;
  localparam logic [47:0] PMINV = 48'h8000_0000_0000;
  localparam longint LMAX = 64'sd140737488355327;
  localparam longint LMIN = -64'sd140737488355328;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, ce = 1'b1, in_valid = 1'b0, cin = 1'b0;
  logic [17:0] a = '0, b = '0, d = '0;
  logic [47:0] c = '0;
  logic [3:0]  opmode = '0;
  logic        vo0, vo1, co0, co1, ov0, ov1;
  logic [47:0] p0, p1;

  dsp_mac_slice #(.SAT_EN(0)) u_wrap (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .b(b), .d(d), .c(c),
    .cin(cin), .opmode(opmode), .out_valid(vo0), .p(p0), .carryout(co0), .ovf(ov0)
  );

  dsp_mac_slice #(.SAT_EN(1)) u_sat (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .b(b), .d(d), .c(c),
    .cin(cin), .opmode(opmode), .out_valid(vo1), .p(p1), .carryout(co1), .ovf(ov1)
  );

  typedef struct packed {
    logic [47:0] p0; logic co0; logic ov0;
    logic [47:0] p1; logic co1; logic ov1;
  } res_t;

  res_t        exp_q[$];
  res_t        got_q[$];
  int          got_cyc[$];
  logic [47:0] acc0 = '0, acc1 = '0;
  int          vectors = 0, errors = 0, cyc = 0;

  // Reference: plain signed arithmetic on 64-bit integers.
  function automatic void model(input logic [17:0] ma, mb, md, input logic [47:0] mc,
                                input logic mcin, input logic [3:0] mop,
                                input logic [47:0] pprev, input bit sat,
                                output logic [47:0] pr, output logic co, output logic ov);
    longint      pre, m, x, ex, ci;
    logic [17:0] pre18;
    logic [49:0] us;
    ci = longint'(mcin);
    case (mop[1:0])
      2'b01:   pre = longint'($signed(md)) + longint'($signed(mb));
      2'b10:   pre = longint'($signed(md)) - longint'($signed(mb));
      default: pre = longint'($signed(mb));
    endcase
    pre18 = pre[17:0];
    m = longint'($signed(ma)) * longint'($signed(pre18));
    case (mop[3:2])
      2'b00:   x = 0;
      2'b10:   x = longint'($signed(pprev));
      default: x = longint'($signed(mc));
    endcase
    if (mop[3:2] == 2'b11) begin
      ex = x - m + ci;
      us = {2'b00, x[47:0]} + {2'b00, ~m[47:0]} + 50'd1 + {49'd0, mcin};
    end else begin
      ex = x + m + ci;
      us = {2'b00, x[47:0]} + {2'b00, m[47:0]} + {49'd0, mcin};
    end
    ov = (ex > LMAX) || (ex < LMIN);
    co = us[48];
    pr = us[47:0];
    if (sat && ov) pr = (ex < 0) ? PMINV : PMAXV;
  endfunction

  task automatic step();
    logic e, r;
    e = ce;
    r = rst;
    @(posedge clk);
    #1;
    cyc++;
    if (e && !r && vo0) begin
      got_q.push_back({p0, co0, ov0, p1, co1, ov1});
      got_cyc.push_back(cyc);
    end
  endtask

  task automatic beat(input logic [17:0] ta, tb, td, input logic [47:0] tc, input logic tcin,
                      input logic [3:0] top, input logic tv, input logic te);
    res_t r;
    a = ta; b = tb; d = td; c = tc; cin = tcin; opmode = top; in_valid = tv; ce = te;
    if (tv && te && !rst) begin
      model(ta, tb, td, tc, tcin, top, acc0, 1'b0, r.p0, r.co0, r.ov0);
      model(ta, tb, td, tc, tcin, top, acc1, 1'b1, r.p1, r.co1, r.ov1);
      acc0 = r.p0;
      acc1 = r.p1;
      exp_q.push_back(r);
    end
    step();
  endtask

  task automatic idle();
    beat('0, '0, '0, '0, 1'b0, 4'b0000, 1'b0, 1'b1);
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (got_q.size() < exp_q.size() && n < bound) begin
      idle();
      n++;
    end
  endtask

  task automatic clear();
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; ce = 1'b1;
    step(); step();
    vectors++;
    if ({vo0, p0, co0, ov0} !== 51'd0) begin
      errors++;
      $display("FAIL reset_wrap: got v=%b p=%h co=%b ov=%b, want all zero", vo0, p0, co0, ov0);
    end
    vectors++;
    if ({vo1, p1, co1, ov1} !== 51'd0) begin
      errors++;
      $display("FAIL reset_sat: got v=%b p=%h co=%b ov=%b, want all zero", vo1, p1, co1, ov1);
    end
    rst = 1'b0; acc0 = '0; acc1 = '0;
    clear();
  endtask

  task automatic test_latency();
    int issue;
    beat(18'd3, 18'd4, 18'd5, '0, 1'b0, 4'b0001, 1'b1, 1'b1);
    issue = cyc;
    drain(10);
    vectors++;
    if (got_q.size() != 1 || got_cyc[0] != issue + 2) begin
      errors++;
      $display("FAIL latency: got %0d results, first at +%0d edges, want 1 at +3",
               got_q.size(), (got_cyc.size() > 0) ? got_cyc[0] - issue + 1 : -1);
    end
    vectors++;
    if (got_q.size() < 1 || got_q[0].p0 !== 48'd27 || got_q[0].co0 !== 1'b0 || got_q[0].ov0 !== 1'b0) begin
      errors++;
      $display("FAIL latency_value: got p=%h co=%b ov=%b, want p=27 co=0 ov=0", p0, co0, ov0);
    end
    clear();
  endtask

  task automatic test_accumulate();
    logic [47:0] want [4] = '{48'd6, 48'd12, 48'd18, 48'd24};
    beat(18'd2, 18'd3, '0, '0, 1'b0, 4'b0000, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) beat(18'd2, 18'd3, '0, '0, 1'b0, 4'b1000, 1'b1, 1'b1);
    drain(10);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (i >= got_q.size() || got_q[i].p0 !== want[i] || got_q[i].p1 !== want[i] ||
          got_cyc[i] != got_cyc[0] + i) begin
        errors++;
        $display("FAIL accumulate[%0d]: got p=%h sat_p=%h, want %0d on consecutive cycles",
                 i, (i < got_q.size()) ? got_q[i].p0 : 48'hx, (i < got_q.size()) ? got_q[i].p1 : 48'hx, want[i]);
      end
    end
    clear();
  endtask

  task automatic test_bubbles();
    beat(18'd2, 18'd3, '0, '0, 1'b0, 4'b0000, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle(); idle();
      beat(18'd2, 18'd3, '0, '0, 1'b0, 4'b1000, 1'b1, 1'b1);
    end
    drain(10);
    idle(); idle(); idle();
    vectors++;
    if (got_q.size() != 4 || p0 !== 48'd24 || p1 !== 48'd24) begin
      errors++;
      $display("FAIL bubbles: got %0d results final p=%h sat_p=%h, want 4 results final 24", got_q.size(), p0, p1);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bubbles[%0d]: got p=%h, want p=%h", i,
                 (i < got_q.size()) ? got_q[i].p0 : 48'hx, exp_q[i].p0);
      end
    end
    clear();
  endtask

  task automatic test_stall();
    int b0;
    logic [47:0] want [4] = '{48'd6, 48'd12, 48'd18, 48'd24};
    beat(18'd2, 18'd3, '0, '0, 1'b0, 4'b0000, 1'b1, 1'b1);
    b0 = cyc;
    beat(18'd2, 18'd3, '0, '0, 1'b0, 4'b1000, 1'b1, 1'b1);
    beat(18'd2, 18'd3, '0, '0, 1'b0, 4'b1000, 1'b1, 1'b1);
    beat(18'd2, 18'd3, '0, '0, 1'b0, 4'b1000, 1'b1, 1'b0);
    beat(18'd2, 18'd3, '0, '0, 1'b0, 4'b1000, 1'b1, 1'b0);
    vectors++;
    if (vo0 !== 1'b1 || p0 !== 48'd6) begin
      errors++;
      $display("FAIL stall_hold: got v=%b p=%h, want v=1 p=6 held", vo0, p0);
    end
    beat(18'd2, 18'd3, '0, '0, 1'b0, 4'b1000, 1'b1, 1'b1);
    drain(10);
    vectors++;
    if (got_cyc.size() != 4 || got_cyc[0] != b0 + 2 || got_cyc[1] != b0 + 5 || got_cyc[3] != b0 + 7) begin
      errors++;
      $display("FAIL stall_timing: got %0d results, first at %0d last at %0d, want 4 at %0d..%0d",
               got_cyc.size(), (got_cyc.size() > 0) ? got_cyc[0] : -1,
               (got_cyc.size() > 0) ? got_cyc[got_cyc.size()-1] : -1, b0 + 2, b0 + 7);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (i >= got_q.size() || got_q[i].p0 !== want[i] || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL stall[%0d]: got p=%h, want %0d", i, (i < got_q.size()) ? got_q[i].p0 : 48'hx, want[i]);
      end
    end
    clear();
  endtask

  task automatic test_saturation();
    beat(18'd1, 18'd1, '0, PMAXV, 1'b0, 4'b0100, 1'b1, 1'b1);
    beat(18'd1, 18'd1, '0, PMINV, 1'b0, 4'b1100, 1'b1, 1'b1);
    beat(18'd1, 18'd1, '0, 48'd5, 1'b0, 4'b0100, 1'b1, 1'b1);
    drain(10);
    vectors++;
    if (got_q.size() < 1 || got_q[0].p0 !== PMINV || got_q[0].ov0 !== 1'b1 ||
        got_q[0].p1 !== PMAXV || got_q[0].ov1 !== 1'b1) begin
      errors++;
      $display("FAIL sat_pos: got wrap p=%h ov=%b sat p=%h ov=%b, want 800000000000/1 7fffffffffff/1",
               (got_q.size() > 0) ? got_q[0].p0 : 48'hx, (got_q.size() > 0) ? got_q[0].ov0 : 1'bx,
               (got_q.size() > 0) ? got_q[0].p1 : 48'hx, (got_q.size() > 0) ? got_q[0].ov1 : 1'bx);
    end
    vectors++;
    if (got_q.size() < 2 || got_q[1].p0 !== PMAXV || got_q[1].co0 !== 1'b1 ||
        got_q[1].p1 !== PMINV || got_q[1].ov1 !== 1'b1) begin
      errors++;
      $display("FAIL sat_neg: got wrap p=%h co=%b sat p=%h, want 7fffffffffff/1 800000000000",
               (got_q.size() > 1) ? got_q[1].p0 : 48'hx, (got_q.size() > 1) ? got_q[1].co0 : 1'bx,
               (got_q.size() > 1) ? got_q[1].p1 : 48'hx);
    end
    vectors++;
    if (got_q.size() < 3 || got_q[2].p0 !== 48'd6 || got_q[2].ov0 !== 1'b0 || got_q[2].ov1 !== 1'b0) begin
      errors++;
      $display("FAIL sat_clear: got p=%h ov=%b sat_ov=%b, want p=6 ov=0", p0, ov0, ov1);
    end
    clear();
  endtask

  task automatic test_sub_carry();
    beat(18'd2, 18'd3, '0, 48'd10, 1'b0, 4'b1100, 1'b1, 1'b1);
    beat(18'd1, 18'd1, '0, 48'd0, 1'b0, 4'b1100, 1'b1, 1'b1);
    drain(10);
    vectors++;
    if (got_q.size() < 1 || got_q[0].p0 !== 48'd4 || got_q[0].co0 !== 1'b1) begin
      errors++;
      $display("FAIL sub_carry: got p=%h co=%b, want p=4 co=1",
               (got_q.size() > 0) ? got_q[0].p0 : 48'hx, (got_q.size() > 0) ? got_q[0].co0 : 1'bx);
    end
    vectors++;
    if (got_q.size() < 2 || got_q[1].p0 !== 48'hFFFF_FFFF_FFFF || got_q[1].co0 !== 1'b0 || got_q[1].ov0 !== 1'b0) begin
      errors++;
      $display("FAIL sub_neg: got p=%h co=%b, want p=ffffffffffff co=0",
               (got_q.size() > 1) ? got_q[1].p0 : 48'hx, (got_q.size() > 1) ? got_q[1].co0 : 1'bx);
    end
    clear();
  endtask

  task automatic test_reset_mid();
    beat(18'd2, 18'd3, '0, '0, 1'b0, 4'b0000, 1'b1, 1'b1);
    beat(18'd2, 18'd3, '0, '0, 1'b0, 4'b1000, 1'b1, 1'b1);
    beat(18'd2, 18'd3, '0, '0, 1'b0, 4'b1000, 1'b1, 1'b1);
    rst = 1'b1;
    beat(18'd2, 18'd3, '0, '0, 1'b0, 4'b1000, 1'b1, 1'b0);
    vectors++;
    if (vo0 !== 1'b0 || p0 !== 48'd0 || vo1 !== 1'b0 || p1 !== 48'd0) begin
      errors++;
      $display("FAIL reset_mid: got v=%b p=%h sat v=%b p=%h, want v=0 p=0", vo0, p0, vo1, p1);
    end
    rst = 1'b0; acc0 = '0; acc1 = '0;
    clear();
    for (int i = 0; i < 4; i++) idle();
    vectors++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL reset_flush: got %0d stale results, want 0", got_q.size());
    end
    beat(18'd2, 18'd3, '0, '0, 1'b0, 4'b1000, 1'b1, 1'b1);
    drain(10);
    vectors++;
    if (got_q.size() != 1 || got_q[0].p0 !== 48'd6 || got_q[0].p1 !== 48'd6) begin
      errors++;
      $display("FAIL reset_first_acc: got p=%h, want 6", p0);
    end
    clear();
  endtask

  task automatic test_random();
    logic te, tv;
    for (int i = 0; i < 400; i++) begin
      te = ($urandom_range(0, 9) != 0);
      tv = ($urandom_range(0, 2) != 0);
      beat(18'($urandom), 18'($urandom), 18'($urandom), {16'($urandom), 32'($urandom)},
           1'($urandom), 4'($urandom), tv, te);
      vectors++;
      if (vo0 !== vo1) begin
        errors++;
        $display("FAIL random_valid: cycle %0d wrap v=%b sat v=%b, want equal", cyc, vo0, vo1);
      end
    end
    drain(20);
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_count: got %0d results, want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL random[%0d]: got p=%h co=%b ov=%b sat_p=%h sat_ov=%b, want p=%h co=%b ov=%b sat_p=%h sat_ov=%b",
                 i, (i < got_q.size()) ? got_q[i].p0 : 48'hx, (i < got_q.size()) ? got_q[i].co0 : 1'bx,
                 (i < got_q.size()) ? got_q[i].ov0 : 1'bx, (i < got_q.size()) ? got_q[i].p1 : 48'hx,
                 (i < got_q.size()) ? got_q[i].ov1 : 1'bx,
                 exp_q[i].p0, exp_q[i].co0, exp_q[i].ov0, exp_q[i].p1, exp_q[i].ov1);
      end
    end
    clear();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_accumulate();
    test_bubbles();
    test_stall();
    test_saturation();
    test_sub_carry();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000 ns, want finished");
    $fatal(1);
  end

endmodule
